// File: rtl/shift_pkg.sv
// Shared types for the shared-shifter arbiter: shift opcode encoding and shift-amount width.
package shift_pkg;

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ILL = 2'b11
  } shift_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer, grants the first requester,
// and moves the pointer past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_any
);

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (enable) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = IDW'((32'(ptr_q) + k) % N);
        if (!grant_any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          grant_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = IDW'((32'(grant_idx) + 32'd1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shifter.sv
// Combinational barrel shifter with one-hot style operation selects.
// When no select is active the result is zero.
module shifter
  import shift_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]       a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               is_lsl,
  input  logic               is_lsr,
  input  logic               is_asr,
  output logic [W-1:0]       result
);

  always_comb begin
    result = '0;
    if (is_lsl) begin
      result = a << shamt;
    end else if (is_lsr) begin
      result = a >> shamt;
    end else if (is_asr) begin
      result = W'($signed(a) >>> shamt);
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between N requesters: round-robin grant into a one-entry
// operand stage, shifter evaluates from the stage, tagged result on a valid/ready port.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [N-1:0][W-1:0] req_a,
  input  logic [N-1:0][W-1:0] req_b,
  input  logic [N-1:0][1:0]   req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_result,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err
);

  logic               s_valid_q, s_valid_d;
  logic [W-1:0]       s_a_q, s_a_d;
  logic [SHAMT_W-1:0] s_b_q, s_b_d;
  shift_op_t          s_op_q, s_op_d;
  logic [IDW-1:0]     s_id_q, s_id_d;

  logic           can_accept;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           is_lsl, is_lsr, is_asr;

  // Only the low shift-amount bits of each B operand reach the shifter.
  logic unused_b_hi;
  always_comb begin
    unused_b_hi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      unused_b_hi = unused_b_hi ^ (^req_b[i][W-1:SHAMT_W]);
    end
  end

  // Gated by rst_n so no port sees ready while reset is asserted.
  assign can_accept = rst_n && (!s_valid_q || rsp_ready);

  rr_arbiter #(
    .N  (N),
    .IDW(IDW)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .enable   (can_accept),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    s_valid_d = s_valid_q;
    s_a_d     = s_a_q;
    s_b_d     = s_b_q;
    s_op_d    = s_op_q;
    s_id_d    = s_id_q;
    if (grant_any) begin
      s_valid_d = 1'b1;
      s_a_d     = req_a[grant_idx];
      s_b_d     = req_b[grant_idx][SHAMT_W-1:0];
      s_op_d    = shift_op_t'(req_op[grant_idx]);
      s_id_d    = grant_idx;
    end else if (s_valid_q && rsp_ready) begin
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_a_q     <= '0;
      s_b_q     <= '0;
      s_op_q    <= SH_LSL;
      s_id_q    <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_a_q     <= s_a_d;
      s_b_q     <= s_b_d;
      s_op_q    <= s_op_d;
      s_id_q    <= s_id_d;
    end
  end

  assign is_lsl = (s_op_q == SH_LSL);
  assign is_lsr = (s_op_q == SH_LSR);
  assign is_asr = (s_op_q == SH_ASR);

  shifter #(
    .W(W)
  ) u_shifter (
    .a     (s_a_q),
    .shamt (s_b_q),
    .is_lsl(is_lsl),
    .is_lsr(is_lsr),
    .is_asr(is_asr),
    .result(rsp_result)
  );

  assign rsp_valid = s_valid_q;
  assign rsp_id    = s_id_q;
  assign rsp_err   = s_valid_q && (s_op_q == SH_ILL);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table, hand-written multi-cycle sequences,
// then random traffic against a queue-free behavioural model of grant order and results.
module tb_shift_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned W   = 32;
  localparam int unsigned IDW = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0][1:0]   req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [W-1:0]        rsp_result;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arbiter #(
    .W  (W),
    .N  (N),
    .IDW(IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Shift semantics as arithmetic: multiply / floor-divide by a power of two.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    longint unsigned p, ua;
    p  = 64'd1 << b[4:0];
    ua = {32'd0, a};
    case (op)
      2'd0:    return 32'(ua * p);
      2'd1:    return 32'(ua / p);
      2'd2:    return a[31] ? ~32'({32'd0, ~a} / p) : 32'(ua / p);
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  logic [N-1:0] onehot;
  logic [N-1:0] exp_g;
  logic [N-1:0] hold;
  int           gi;
  logic         m_valid;
  logic [31:0]  m_res;
  int           m_id;
  logic         m_err;
  int           m_ptr;

  initial begin
    tbl[0] = '{0, 32'h0000_00F0, 32'd4,         2'b00, 32'h0000_0F00, 1'b0};
    tbl[1] = '{1, 32'h8000_0000, 32'h0000_0021, 2'b10, 32'hC000_0000, 1'b0};
    tbl[2] = '{0, 32'h8000_0000, 32'h0000_0021, 2'b01, 32'h4000_0000, 1'b0};
    tbl[3] = '{1, 32'h0000_ABCD, 32'd8,         2'b00, 32'h00AB_CD00, 1'b0};
    tbl[4] = '{0, 32'h0000_0001, 32'h0000_001F, 2'b00, 32'h8000_0000, 1'b0};
    tbl[5] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 1'b0};
    tbl[6] = '{0, 32'hFFFF_FFFF, 32'd3,         2'b11, 32'h0000_0000, 1'b1};

    // Reset: outputs quiet even with requests pending.
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one request at a time.
    for (int i = 0; i < 7; i++) begin
      req_valid              = '0;
      req_valid[tbl[i].port] = 1'b1;
      req_a[tbl[i].port]     = tbl[i].a;
      req_b[tbl[i].port]     = tbl[i].b;
      req_op[tbl[i].port]    = tbl[i].op;
      rsp_ready              = 1'b1;
      onehot                 = '0;
      onehot[tbl[i].port]    = 1'b1;
      #1;
      check("tbl_req_ready", req_ready, onehot);
      @(posedge clk);
      #1;
      req_valid = '0;
      check("tbl_rsp_valid", rsp_valid, 1);
      check("tbl_rsp_result", rsp_result, tbl[i].exp_res);
      check("tbl_rsp_id", rsp_id, tbl[i].port);
      check("tbl_rsp_err", rsp_err, tbl[i].exp_err);
    end

    // Pointer moved past port 0 after the illegal op, so port 1 wins the tie.
    req_valid = '1;
    req_a[1]  = 32'h11;
    req_b[1]  = 32'd1;
    req_op[1] = 2'b00;
    #1;
    check("ill_ptr_advance", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("ill_next_id", rsp_id, 1);
    check("ill_next_result", rsp_result, 32'h22);

    // Back-pressure: hold three cycles, then drain and accept together.
    req_valid = 2'b01;
    req_a[0]  = 32'h1;
    req_b[0]  = 32'd1;
    req_op[0] = 2'b00;
    #1;
    check("bp_first_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    req_a[1]  = 32'h30;
    req_b[1]  = 32'd2;
    req_op[1] = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_result", rsp_result, 32'h2);
      check("bp_rsp_id", rsp_id, 0);
      @(posedge clk);
      #1;
    end
    check("bp_hold_result", rsp_result, 32'h2);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("bp_nobubble_valid", rsp_valid, 1);
    check("bp_nobubble_result", rsp_result, 32'hC);
    check("bp_nobubble_id", rsp_id, 1);

    // Async reset while a result is held.
    rsp_ready = 1'b0;
    #1;
    check("ar_held_valid", rsp_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", rsp_valid, 0);
    check("ar_result_zero", rsp_result, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ar_no_response", rsp_valid, 0);

    // Fairness with both ports continuously requesting.
    req_valid = '1;
    req_a[0]  = 32'h1;
    req_b[0]  = 32'd0;
    req_op[0] = 2'b00;
    req_a[1]  = 32'h2;
    req_b[1]  = 32'd0;
    req_op[1] = 2'b00;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 0) check("ar_first_grant", req_ready, 2'b01);
      check("rr_onehot", $countones(req_ready), 1);
      @(posedge clk);
      #1;
      check("rr_id", rsp_id, k % 2);
      check("rr_result", rsp_result, (k % 2) + 1);
    end
    req_valid = '0;

    // Random traffic against the behavioural model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_res   = '0;
    m_id    = 0;
    m_err   = 1'b0;
    m_ptr   = 0;
    hold    = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        check("rnd_rsp_result", rsp_result, m_res);
        check("rnd_rsp_id", rsp_id, m_id);
        check("rnd_rsp_err", rsp_err, m_err);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i]     = $urandom;
          req_b[i]     = $urandom;
          req_op[i]    = 2'($urandom_range(0, 3));
        end
        hold[i] = req_valid[i];
      end
      exp_g = '0;
      gi    = 0;
      if (!m_valid || rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          if (exp_g == '0 && req_valid[(m_ptr + k) % N]) begin
            gi        = (m_ptr + k) % N;
            exp_g[gi] = 1'b1;
          end
        end
      end
      #1;
      check("rnd_req_ready", req_ready, exp_g);
      @(posedge clk);
      if (exp_g != '0) begin
        m_valid  = 1'b1;
        m_res    = ref_shift(req_a[gi], req_b[gi], req_op[gi]);
        m_id     = gi;
        m_err    = (req_op[gi] == 2'b11);
        m_ptr    = (gi + 1) % N;
        hold[gi] = 1'b0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single combinational barrel shifter (`shifter`, W-bit, LSL/LSR/ASR) between N requesters, e.g. the integer execute lane and the address-generation/multiply-assist path. Requests arrive on per-port valid/ready handshakes, a round-robin arbiter picks one per cycle, and operands are registered into a one-entry stage. The shifter evaluates from that stage, and the result is returned on a single tagged valid/ready response port. Sustains one shift per cycle at one cycle of latency.

## Interface
- `W`, 32: operand/result width; shift amount is `B[4:0]` (W=32 only supported value for shamt width).
- `N`, 2: number of requesters (2..8).
- `IDW`, $clog2(N) (min 1): response tag width.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N  per-requester request valid.
- `req_ready`  out  N  per-requester accept; at most one bit set.
- `req_a`  in  N×W  operand to shift.
- `req_b`  in  N×W  shift amount source (bits [4:0] used).
- `req_op`  in  N×2  `shift_op_t`: 00 LSL, 01 LSR, 10 ASR, 11 illegal.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_result`  out  W  shifter result for held request.
- `rsp_id`  out  IDW  index of requester that issued it.
- `rsp_err`  out  1  held op was illegal (11); result forced 0.

## Operation
- Stage register: `s_valid`, `s_a`, `s_b`, `s_op`, `s_id`. `rsp_valid = s_valid`; `rsp_id = s_id`.
- `can_accept = !s_valid || rsp_ready`.
- Grant: when `can_accept`, pick the first `req_valid[i]` scanning from `rr_ptr` upward, modulo N. `req_ready[i]` = grant[i]. No valid requester means no grant and all `req_ready` are 0.
- Transfer on a requester port happens when `req_valid[i] && req_ready[i]`. On transfer the stage loads that port's operands with `s_id = i` and `s_valid = 1`, and `rr_ptr` becomes `(i+1) mod N`.
- If there is no transfer and `rsp_valid && rsp_ready`, then `s_valid` clears.
- If `s_valid && !rsp_ready`, the stage holds. All `req_ready` are 0 and `rsp_*` stay stable.
- Shifter drive: `isLsl = (s_op==00)`, `isLsr = (s_op==01)`, `isAsr = (s_op==10)`. For op 11 no select is active, so the shifter yields 0. In that case `rsp_err = s_valid && s_op==11`.
- Requester rules: `req_*` stable while valid and not ready. Valid is never dependent on ready. `req_ready` may depend combinationally on `req_valid`, but not on `req_a/b/op`.
- `rr_ptr` changes only on a transfer. A requester that holds valid is granted within N accept cycles.

## Timing
- Reset (async assert, sync-safe release): `s_valid=0`, `s_a/s_b=0`, `s_op=00`, `s_id=0`, `rr_ptr=0`. Resulting outputs: `rsp_valid=0`, `rsp_result=0`, `rsp_id=0`, `rsp_err=0`, `req_ready=0` while `rst_n` low.
- Latency: a request accepted in cycle t appears on `rsp_*` in cycle t+1.
- Throughput: 1/cycle while `rsp_ready` is held high.
- Simultaneous drain and accept: when `rsp_valid && rsp_ready` coincides with a transfer, the stage is replaced by the new request (no bubble).
- Reset mid-operation drops any held result, with no response emitted. Requesters re-present after reset.
- `rr_ptr` wraps from N-1 to 0.

## Structure
- Shared package `shift_pkg`: `shift_op_t` enum (`SH_LSL=2'b00`, `SH_LSR=2'b01`, `SH_ASR=2'b10`, `SH_ILL=2'b11`) and `SHAMT_W=5`.
- Sub-modules:
  - One instance of the existing `shifter` (W, flags unused).
  - An optional `rr_arbiter #(N)` sub-module (req, enable, grant, pointer update) is natural and reusable.
- Expected RTL size is about 150–250 lines.

## Test plan
- Reset and single shift:
  - Stimulus: hold `rst_n=0` and check all outputs are 0; release. Requester 0 sends A=0x0000_00F0, B=4, op LSL with `rsp_ready=1`.
  - Required response: next cycle `rsp_valid=1`, `rsp_result=0x0000_0F00`, `rsp_id=0`, `rsp_err=0`.
- ASR vs LSR:
  - Stimulus: A=0x8000_0000, B=0x0000_0021 (shamt 1), issued once as op ASR and once as op LSR.
  - Required response: 0xC000_0000 for ASR, then 0x4000_0000 for LSR; upper B bits ignored.
- Round-robin fairness:
  - Stimulus: both requesters hold valid for 6 cycles with `rsp_ready=1`.
  - Required response: `rsp_id` sequence 0,1,0,1,0,1; never more than one `req_ready` bit set.
- Back-pressure:
  - Stimulus: after a transfer, hold `rsp_ready=0` for 3 cycles.
  - Required response: `rsp_*` stable, `req_ready=0`; on release, drain and accept the next request in the same cycle with no bubble.
- Illegal op:
  - Stimulus: op=11, A=0xFFFF_FFFF, B=3.
  - Required response: `rsp_result=0`, `rsp_err=1`, `rsp_id` correct; `rr_ptr` still advances.
- Async reset mid-flight:
  - Stimulus: assert `rst_n` low while `rsp_valid=1` and `rsp_ready=0`.
  - Required response: `rsp_valid` drops immediately without waiting for a clock edge. After release the first grant goes to requester 0.
